// File: rtl/decoder_onehot_seq_pkg.sv
// Shared types and helpers for the registered one-hot decoder.
package decoder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        PULSE = 2'd2
    } state_t;

    localparam int MAX_SEL_W = 6;
    localparam int MAX_OUT_W = 1 << MAX_SEL_W;

    function automatic int cnt_width(input int pulse_len);
        return $clog2(pulse_len + 1);
    endfunction

    // Callers size-cast the result down to their own output width.
    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] sel);
        return MAX_OUT_W'(1) << sel;
    endfunction

endpackage

// File: rtl/decoder_onehot_seq_pulse_timer.sv
// Loadable down-counter that parks at zero; flags the final count.
module pulse_timer
    import decoder_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] value,
    output logic             last
);

    logic [CNT_W-1:0] cnt_p1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_p1 <= '0;
        end else if (load) begin
            cnt_p1 <= load_val;
        end else if (cnt_p1 != '0) begin
            cnt_p1 <= cnt_p1 - CNT_W'(1);
        end
    end

    assign value = cnt_p1;
    assign last  = (cnt_p1 == CNT_W'(1));

endmodule

// File: rtl/decoder_onehot_seq.sv
// Registered binary-to-one-hot decoder with level and pulse modes.
// Optional sticky protocol-violation flag: define DECODER_ONEHOT_SEQ_DROP_ERR_EN.
module decoder_onehot_seq
    import decoder_pkg::*;
#(
    parameter int SEL_W     = 2,
    parameter int PULSE_LEN = 4,
    localparam int OUT_W    = 1 << SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] in_sel,
    input  logic             in_en,
    input  logic             mode,
    output logic [OUT_W-1:0] out_onehot,
    output logic             out_valid,
    output logic             busy
`ifdef DECODER_ONEHOT_SEQ_DROP_ERR_EN
    ,
    output logic             drop_err
`endif
);

    localparam int CNT_W = cnt_width(PULSE_LEN);

    state_t               state_p1;
    logic [OUT_W-1:0]     onehot_p1;
    logic                 vld_p1;
    logic [OUT_W-1:0]     dec_p0;
    logic [MAX_SEL_W-1:0] sel_ext_p0;
    logic                 accept_p0;
    logic                 last_p0;
    logic [CNT_W-1:0]     cnt_p1;

    // Stage p0: request decode
    always_comb begin
        sel_ext_p0              = '0;
        sel_ext_p0[SEL_W-1:0]   = in_sel;
        dec_p0                  = in_en ? OUT_W'(onehot(sel_ext_p0)) : '0;
    end

    assign in_ready  = (state_p1 != PULSE) || last_p0;
    assign accept_p0 = in_valid && in_ready;

    pulse_timer #(
        .CNT_W (CNT_W)
    ) u_pulse_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (accept_p0 && mode),
        .load_val (CNT_W'(PULSE_LEN)),
        .value    (cnt_p1),
        .last     (last_p0)
    );

    // Stage p1: registered output and control state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_p1  <= IDLE;
            onehot_p1 <= '0;
            vld_p1    <= 1'b0;
        end else if (accept_p0) begin
            onehot_p1 <= dec_p0;
            vld_p1    <= in_en;
            state_p1  <= mode ? PULSE : HOLD;
        end else if (state_p1 == PULSE && last_p0) begin
            state_p1  <= IDLE;
            onehot_p1 <= '0;
            vld_p1    <= 1'b0;
        end
    end

    assign out_onehot = onehot_p1;
    assign out_valid  = vld_p1;
    assign busy       = (cnt_p1 != '0);

`ifdef DECODER_ONEHOT_SEQ_DROP_ERR_EN
    logic [SEL_W-1:0] prev_sel_p1;
    logic             prev_en_p1;
    logic             prev_blk_p1;
    logic             drop_err_p1;
    logic             blk_p0;

    assign blk_p0 = in_valid && !in_ready;

    // A request only counts as altered if it was already stalled last cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_blk_p1 <= 1'b0;
            drop_err_p1 <= 1'b0;
        end else begin
            prev_blk_p1 <= blk_p0;
            if (blk_p0 && prev_blk_p1 && (in_sel != prev_sel_p1 || in_en != prev_en_p1)) begin
                drop_err_p1 <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        prev_sel_p1 <= in_sel;
        prev_en_p1  <= in_en;
    end

    assign drop_err = drop_err_p1;
`endif

endmodule

// File: doc/decoder_onehot_seq.md
Name: decoder_onehot_seq

Overview:
- Parametrised, registered binary-to-one-hot decoder. Successor to the team's combinational 2-to-4 decoder.
- Accepts a SEL_W-bit select through a valid/ready handshake and drives a 2**SEL_W one-hot output one cycle later.
- Two runtime modes:
  - level: output held until the next accepted request.
  - pulse: output asserted for PULSE_LEN cycles, then cleared.
- Used for chip-select and strobe generation in downstream datapaths.

Parameters:
- SEL_W, 2, select width; output width OUT_W = 2**SEL_W (legal range 1..6).
- PULSE_LEN, 4, cycles the one-hot output stays asserted in pulse mode (legal range 1..255).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low. Sampled on the rising edge of clk.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request this cycle.
- in_sel  in  SEL_W  binary select. Value k selects out_onehot[k]; in_sel MSB is the high-order index bit.
- in_en  in  1  decode enable. When 0, an accepted request produces an all-zero output.
- mode  in  1  0 = level, 1 = pulse. Sampled only on accept.
- out_onehot  out  OUT_W  registered one-hot (or all-zero) output.
- out_valid  out  1  high while out_onehot carries a decoded value.
- busy  out  1  high while in the PULSE state.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, out_onehot=0, out_valid=0, cnt=0, in_ready=1, busy=0.
  - Reset overrides any in-progress pulse or hold.
- Accept condition: in_valid && in_ready at the rising edge.
- Latency: exactly 1 cycle from accept to out_onehot update.
- Decode rule on accept:
  - out_onehot = in_en ? (1 << in_sel) : 0.
  - out_valid = in_en.
  - No X propagation; every in_sel value is legal.
- States:
  - IDLE: out_onehot=0, out_valid=0, in_ready=1.
    - Accept with mode=0 -> HOLD.
    - Accept with mode=1 -> PULSE, cnt=PULSE_LEN.
  - HOLD: output held, in_ready=1.
    - Accept -> re-decode; go to HOLD or PULSE per the sampled mode.
    - No accept -> stay in HOLD, output unchanged.
  - PULSE: busy=1, cnt decrements by 1 each cycle.
    - in_ready=1 only when cnt==1 (last pulse cycle). In that cycle:
      - Accept -> new decode next cycle, no zero gap (back-to-back).
      - No accept -> IDLE with out_onehot=0.
- PULSE_LEN=1: PULSE lasts one cycle and in_ready stays high continuously.
- Pulse with in_en=0: the block still enters PULSE and occupies PULSE_LEN cycles with all-zero output and busy=1. This keeps timing deterministic.
- Counter width: $clog2(PULSE_LEN+1). The counter never wraps; it saturates at 0 in non-PULSE states.
- in_valid while in_ready=0: the request is ignored. The requester must hold in_valid, in_sel, in_en and mode stable until accepted.
- One-hot invariant: $countones(out_onehot) <= 1 in every cycle.

Optional Feature:
- Macro: DECODER_ONEHOT_SEQ_DROP_ERR_EN.
- Defined:
  - Adds output port drop_err (1 bit, reset 0).
  - drop_err is set when in_valid=1 and in_ready=0 and in_sel or in_en changes from the previous cycle, i.e. a protocol violation.
  - Sticky until reset.
- Not defined: port absent, no extra logic.

Decomposition:
- Package decoder_pkg:
  - state enum {IDLE, HOLD, PULSE}, 2 bits.
  - function onehot(sel) returning the OUT_W vector.
  - localparam helper for counter width.
- Sub-module pulse_timer: loadable down-counter with load, value, and last (cnt==1) outputs. Instantiated once.

Test Plan:
- Reset then level mode: SEL_W=2; accept in_sel=2, in_en=1, mode=0 -> next cycle out_onehot=4'b0100, out_valid=1, held for 10 idle cycles.
- Pulse mode: PULSE_LEN=4; accept in_sel=3 -> out_onehot=4'b1000 for exactly 4 cycles, busy=1, in_ready=0 for the first 3 of them, then 0 and IDLE.
- Back-to-back pulses: accept in_sel=1 in the cnt==1 cycle of the previous pulse -> output goes 4'b1000 to 4'b0010 with no zero cycle.
- in_en=0, mode=1: out_onehot=0, out_valid=0, busy=1 for 4 cycles. in_valid held high is accepted only on the last cycle.
- Reset mid-pulse: rst_n=0 at cnt=2 -> next cycle all outputs 0, in_ready=1. Accept immediately after reset works.
- Exhaustive sweep with SEL_W=3, level mode: all 8 selects -> out_onehot == 1<<sel. With DECODER_ONEHOT_SEQ_DROP_ERR_EN, changing in_sel while blocked sets drop_err=1.
